hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 3-stage pipeline: D (decode/regfile read), X (execute), MW (memory/writeback).
- Keeps a shadow copy of destination-register info for the X and MW slots.
- Drives the MW→D forwarding selects (wb2d_a/wb2d_b) consumed by the decode read logic, registered MW→X forwarding selects, load-use stalls and branch-redirect kills.
- Also provides performance counters for stall and flush cycles.

Parameters:
- LOAD_USE_STALL, 1, 1 = insert one bubble on a load-use dependence; 0 = no load-use stall (synchronous-read memory timing allows direct MW→X forwarding)
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- d_valid  in  1  D holds a real instruction
- d_rs1  in  5  D source register 1 index
- d_rs2  in  5  D source register 2 index
- d_uses_rs1  in  1  D instruction reads rs1
- d_uses_rs2  in  1  D instruction reads rs2
- d_rd  in  5  D destination register index
- d_we  in  1  D instruction writes rd
- d_is_load  in  1  D instruction is a load
- x_redirect  in  1  branch/jump taken, resolved in X this cycle
- mem_busy  in  1  data/instruction memory not ready; freeze the pipeline
- wb2d_a  out  1  D rs1 takes the writeback value
- wb2d_b  out  1  D rs2 takes the writeback value
- x_fwd_a  out  1  X operand A takes the MW result (registered)
- x_fwd_b  out  1  X operand B takes the MW result (registered)
- stall_f  out  1  hold PC/fetch
- stall_d  out  1  hold the D pipeline register
- kill_d  out  1  the instruction advancing D→X becomes a bubble
- pipe_adv  out  1  pipeline advances this cycle
- stall_cnt  out  CNT_W  cycles with stall_d=1
- flush_cnt  out  CNT_W  cycles with kill_d=1 caused by x_redirect

Behaviour:
- Reset (async, rst_n=0) clears:
  - x_valid, mw_valid, x_we, mw_we, x_load, x_rd, mw_rd
  - x_fwd_a, x_fwd_b
  - both counters
  - state ← RUN
- While reset is asserted, all combinational outputs are 0.
- Reset mid-operation discards all shadow state immediately; there is no partial drain.
- Shadow slots:
  - X slot: x_valid, x_rd, x_we, x_load.
  - MW slot: mw_valid, mw_rd, mw_we.
- pipe_adv = !mem_busy. When pipe_adv=1:
  - MW ← X.
  - X ← D fields, with x_valid = d_valid & !kill_d & !loaduse.
- When mem_busy=1, all registers hold, including x_fwd_* and counters. Outputs:
  - stall_f=1, stall_d=1
  - kill_d=0
  - wb2d_*: still evaluated combinationally from held state.
- Writes to x0 never match. A match requires rd≠0 and the uses_* bit set.
- wb2d_a (combinational) = mw_valid & mw_we & mw_rd==d_rs1 & d_uses_rs1 & d_rs1≠0. wb2d_b is the same with rs2.
- x_fwd_a is registered on pipe_adv:
  - Condition: x_valid & x_we & x_rd==d_rs1 & d_uses_rs1 & d_rs1≠0 & !kill_d & !loaduse.
  - Otherwise it is loaded with 0. x_fwd_b is the same with rs2.
  - Latency: 1 cycle.
- loaduse (combinational) = LOAD_USE_STALL & d_valid & x_valid & x_load & (match on rs1 or rs2).
- State machine (2 states):
  - RUN:
    - loaduse & !x_redirect & !mem_busy → assert stall_f, stall_d, kill_d; go to LUSTALL.
    - x_redirect & !mem_busy → kill_d=1, stall_f=0 (PC takes the target); flush_cnt+1; stay in RUN.
  - LUSTALL (exactly 1 cycle):
    - The load is now in MW, so the dependent in D is served by wb2d_*.
    - Outputs are normal; return to RUN on pipe_adv.
    - loaduse cannot re-fire here because x_valid=0.
- Priority: mem_busy > x_redirect > loaduse. Redirect with loaduse in the same cycle: kill only, no stall, no LUSTALL.
- Counters wrap modulo 2^CNT_W.
  - stall_cnt increments in every cycle where stall_d=1 & !mem_busy.
  - Cycles stalled by mem_busy are not counted.

Decomposition:
- Shared package/header: the RUN/LUSTALL state encodings and the REG_X0 = 5'd0 constant.
- One natural sub-module, hazard_match: combinational rd/rs compare with the x0 and uses_* qualifiers, instantiated four times (MW-rs1, MW-rs2, X-rs1, X-rs2).

Test Plan:
- Back-to-back dependence: add x5 then add x6,x5,x1 → on the cycle after the 2nd instruction enters X, x_fwd_a=1; no stall; stall_cnt=0.
- Two-apart dependence: write x7; nop; read x7 in D while the writer is in MW → wb2d_a=1, x_fwd_a=0.
- Load-use: lw x8 then add x9,x8,x8 with LOAD_USE_STALL=1:
  - stall_d=1 and kill_d=1 for exactly 1 cycle.
  - Next cycle wb2d_a=wb2d_b=1.
  - stall_cnt=1.
- x0 and uses filtering:
  - Write x0, then read x0 → no forwarding.
  - Write x3 while D has d_uses_rs2=0 with rs2=3 → wb2d_b=0.
- Redirect coincident with load-use → kill_d=1, stall_d=0, flush_cnt=1, state stays RUN. mem_busy held 3 cycles mid-sequence → all outputs and counters frozen, then resume identically.
- Assert rst_n low while in LUSTALL → all outputs 0 asynchronously; after release, state is RUN and counters are 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller of the D/X/MW pipeline.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        LUSTALL = 1'b1
    } hc_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side request and hazard-control response bundle between pipeline and hazard_ctrl.
// Level signals, no handshake: the pipeline drives D-slot info every cycle, the controller answers in the same cycle.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             d_valid;
    logic [4:0]       d_rs1;
    logic [4:0]       d_rs2;
    logic             d_uses_rs1;
    logic             d_uses_rs2;
    logic [4:0]       d_rd;
    logic             d_we;
    logic             d_is_load;
    logic             x_redirect;
    logic             mem_busy;
    logic             wb2d_a;
    logic             wb2d_b;
    logic             x_fwd_a;
    logic             x_fwd_b;
    logic             stall_f;
    logic             stall_d;
    logic             kill_d;
    logic             pipe_adv;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output d_valid, d_rs1, d_rs2, d_uses_rs1, d_uses_rs2, d_rd, d_we, d_is_load,
        output x_redirect, mem_busy,
        input  wb2d_a, wb2d_b, x_fwd_a, x_fwd_b, stall_f, stall_d, kill_d, pipe_adv,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  d_valid, d_rs1, d_rs2, d_uses_rs1, d_uses_rs2, d_rd, d_we, d_is_load,
        input  x_redirect, mem_busy,
        output wb2d_a, wb2d_b, x_fwd_a, x_fwd_b, stall_f, stall_d, kill_d, pipe_adv,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_match.sv
// Producer/consumer register compare; writes to x0 and unused source operands never match.
module hazard_match
    import hazard_ctrl_pkg::*;
(
    input  logic       valid,
    input  logic       we,
    input  logic [4:0] rd,
    input  logic [4:0] rs,
    input  logic       uses,
    output logic       hit
);
    assign hit = valid & we & uses & (rs != REG_X0) & (rd == rs);
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: shadow X/MW destination info, forwarding selects,
// load-use stall FSM, redirect kill and stall/flush performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    hazard_ctrl_if.slave    bus,
    output hc_state_e       state
);
    logic             x_valid, x_we, x_load;
    logic [4:0]       x_rd;
    logic             mw_valid, mw_we;
    logic [4:0]       mw_rd;
    logic             x_fwd_a_q, x_fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    hc_state_e        state_q, state_d;

    logic mw_hit_a, mw_hit_b, x_hit_a, x_hit_b;
    logic loaduse, adv, stall_f, stall_d, kill_d, flush_inc;

    hazard_match u_mw_a (.valid(mw_valid), .we(mw_we), .rd(mw_rd), .rs(bus.d_rs1),
                         .uses(bus.d_uses_rs1), .hit(mw_hit_a));
    hazard_match u_mw_b (.valid(mw_valid), .we(mw_we), .rd(mw_rd), .rs(bus.d_rs2),
                         .uses(bus.d_uses_rs2), .hit(mw_hit_b));
    hazard_match u_x_a  (.valid(x_valid), .we(x_we), .rd(x_rd), .rs(bus.d_rs1),
                         .uses(bus.d_uses_rs1), .hit(x_hit_a));
    hazard_match u_x_b  (.valid(x_valid), .we(x_we), .rd(x_rd), .rs(bus.d_rs2),
                         .uses(bus.d_uses_rs2), .hit(x_hit_b));

    assign loaduse = (LOAD_USE_STALL != 0) & bus.d_valid & x_valid & x_load & (x_hit_a | x_hit_b);
    assign adv     = rst_n & ~bus.mem_busy;

    // Priority mem_busy > x_redirect > loaduse; everything reads 0 while reset is held.
    always_comb begin
        state_d   = state_q;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        kill_d    = 1'b0;
        flush_inc = 1'b0;
        if (rst_n) begin
            if (bus.mem_busy) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
            end else if (bus.x_redirect) begin
                kill_d    = 1'b1;
                flush_inc = 1'b1;
                state_d   = RUN;
            end else begin
                case (state_q)
                    RUN: begin
                        if (loaduse) begin
                            stall_f = 1'b1;
                            stall_d = 1'b1;
                            kill_d  = 1'b1;
                            state_d = LUSTALL;
                        end
                    end
                    LUSTALL: state_d = RUN;
                    default: state_d = RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            x_valid     <= 1'b0;
            x_we        <= 1'b0;
            x_load      <= 1'b0;
            x_rd        <= REG_X0;
            mw_valid    <= 1'b0;
            mw_we       <= 1'b0;
            mw_rd       <= REG_X0;
            x_fwd_a_q   <= 1'b0;
            x_fwd_b_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (adv) begin
                mw_valid  <= x_valid;
                mw_we     <= x_we;
                mw_rd     <= x_rd;
                x_valid   <= bus.d_valid & ~kill_d & ~loaduse;
                x_we      <= bus.d_we;
                x_load    <= bus.d_is_load;
                x_rd      <= bus.d_rd;
                x_fwd_a_q <= x_hit_a & ~kill_d & ~loaduse;
                x_fwd_b_q <= x_hit_b & ~kill_d & ~loaduse;
                if (stall_d)   stall_cnt_q <= stall_cnt_q + 1'b1;
                if (flush_inc) flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.wb2d_a    = rst_n & mw_hit_a;
    assign bus.wb2d_b    = rst_n & mw_hit_b;
    assign bus.x_fwd_a   = x_fwd_a_q;
    assign bus.x_fwd_b   = x_fwd_b_q;
    assign bus.stall_f   = stall_f;
    assign bus.stall_d   = stall_d;
    assign bus.kill_d    = kill_d;
    assign bus.pipe_adv  = adv;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
    assign state         = state_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: each driven cycle pushes its expected response,
// a monitor pops and compares on the falling edge.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int CW = 16;
    localparam int W  = 9 + 2 * CW;

    logic      clk;
    logic      rst_n;
    hc_state_e state;

    hazard_ctrl_if #(.CNT_W(CW)) bus ();

    hazard_ctrl #(.LOAD_USE_STALL(1), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .state (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;
    logic         done   = 1'b0;

    // flags = {wb2d_a, wb2d_b, x_fwd_a, x_fwd_b, stall_f, stall_d, kill_d, pipe_adv, lustall}
    task automatic step(input string name, input logic rst, input logic dv,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld, input logic redir, input logic busy,
                        input logic [8:0] flags, input int scnt, input int fcnt);
        logic [CW-1:0] s;
        logic [CW-1:0] f;
        @(posedge clk);
        #1;
        bus.d_valid    = dv;
        bus.d_rs1      = rs1;
        bus.d_rs2      = rs2;
        bus.d_uses_rs1 = u1;
        bus.d_uses_rs2 = u2;
        bus.d_rd       = rd;
        bus.d_we       = we;
        bus.d_is_load  = ld;
        bus.x_redirect = redir;
        bus.mem_busy   = busy;
        rst_n          = rst;
        s = CW'(scnt);
        f = CW'(fcnt);
        exp_q.push_back({flags, s, f});
        name_q.push_back(name);
    endtask

    task automatic nop(input string name, input logic rst, input logic busy,
                       input logic [8:0] flags, input int scnt, input int fcnt);
        step(name, rst, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, busy,
             flags, scnt, fcnt);
    endtask

    // driver
    initial begin
        rst_n          = 1'b0;
        bus.d_valid    = 1'b0;
        bus.d_rs1      = 5'd0;
        bus.d_rs2      = 5'd0;
        bus.d_uses_rs1 = 1'b0;
        bus.d_uses_rs2 = 1'b0;
        bus.d_rd       = 5'd0;
        bus.d_we       = 1'b0;
        bus.d_is_load  = 1'b0;
        bus.x_redirect = 1'b0;
        bus.mem_busy   = 1'b0;

        step("reset_hold", 0, 1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 1, 9'b00_00_000_0_0, 0, 0);
        nop ("reset_rel",  1, 0, 9'b00_00_000_1_0, 0, 0);
        // back-to-back: add x5 ; add x6,x5,x1
        step("b2b_wr",    1, 1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 0, 9'b00_00_000_1_0, 0, 0);
        step("b2b_rd",    1, 1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0, 9'b00_00_000_1_0, 0, 0);
        nop ("b2b_fwd",   1, 0, 9'b00_10_000_1_0, 0, 0);
        // two apart: write x7 ; nop ; read x7
        step("two_wr",    1, 1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 0, 0, 0, 9'b00_00_000_1_0, 0, 0);
        nop ("two_gap",   1, 0, 9'b00_00_000_1_0, 0, 0);
        step("two_wb2d",  1, 1, 5'd7, 5'd0, 1, 0, 5'd9, 1, 0, 0, 0, 9'b10_00_000_1_0, 0, 0);
        nop ("two_nofwd", 1, 0, 9'b00_00_000_1_0, 0, 0);
        // load-use: lw x8 ; add x9,x8,x8
        step("lu_load",   1, 1, 5'd2, 5'd0, 1, 0, 5'd8, 1, 1, 0, 0, 9'b00_00_000_1_0, 0, 0);
        step("lu_stall",  1, 1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 0, 9'b00_00_111_1_0, 0, 0);
        step("lu_wb2d",   1, 1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 0, 9'b11_00_000_1_1, 1, 0);
        nop ("lu_after",  1, 0, 9'b00_00_000_1_0, 1, 0);
        // x0 / uses filtering
        step("x0_wr",     1, 1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 9'b00_00_000_1_0, 1, 0);
        step("x0_rd_x",   1, 1, 5'd0, 5'd0, 1, 1, 5'd4, 1, 0, 0, 0, 9'b00_00_000_1_0, 1, 0);
        step("x0_rd_mw",  1, 1, 5'd0, 5'd0, 1, 1, 5'd3, 1, 0, 0, 0, 9'b00_00_000_1_0, 1, 0);
        nop ("x0_gap",    1, 0, 9'b00_00_000_1_0, 1, 0);
        step("uses_filt", 1, 1, 5'd3, 5'd3, 1, 0, 5'd10, 1, 0, 0, 0, 9'b10_00_000_1_0, 1, 0);
        nop ("uses_after",1, 0, 9'b00_00_000_1_0, 1, 0);
        // X->rs2 forward held across a busy cycle
        step("fb_wr",     1, 1, 5'd0, 5'd0, 0, 0, 5'd11, 1, 0, 0, 0, 9'b00_00_000_1_0, 1, 0);
        step("fb_rd",     1, 1, 5'd1, 5'd11, 1, 1, 5'd12, 1, 0, 0, 0, 9'b00_00_000_1_0, 1, 0);
        nop ("fb_busy",   1, 1, 9'b00_01_110_0_0, 1, 0);
        nop ("fb_held",   1, 0, 9'b00_01_000_1_0, 1, 0);
        // redirect coincident with load-use, then mem_busy for 3 cycles
        step("rl_load",   1, 1, 5'd2, 5'd0, 1, 0, 5'd13, 1, 1, 0, 0, 9'b00_00_000_1_0, 1, 0);
        step("rl_redir",  1, 1, 5'd13, 5'd13, 1, 1, 5'd14, 1, 0, 1, 0, 9'b00_00_001_1_0, 1, 0);
        for (int i = 0; i < 3; i++)
            step("busy_frz", 1, 1, 5'd13, 5'd0, 1, 0, 5'd15, 1, 0, 0, 1, 9'b10_00_110_0_0, 1, 1);
        step("busy_resume", 1, 1, 5'd13, 5'd0, 1, 0, 5'd15, 1, 0, 0, 0, 9'b10_00_000_1_0, 1, 1);
        // reset while in LUSTALL
        step("rs_load",   1, 1, 5'd0, 5'd0, 0, 0, 5'd16, 1, 1, 0, 0, 9'b00_00_000_1_0, 1, 1);
        step("rs_stall",  1, 1, 5'd16, 5'd0, 1, 0, 5'd17, 1, 0, 0, 0, 9'b00_00_111_1_0, 1, 1);
        step("rs_lustall",1, 1, 5'd16, 5'd0, 1, 0, 5'd17, 1, 0, 0, 1, 9'b10_00_110_0_1, 2, 1);
        step("rs_assert", 0, 1, 5'd16, 5'd0, 1, 0, 5'd17, 1, 0, 0, 1, 9'b00_00_000_0_0, 0, 0);
        nop ("rs_held",   0, 0, 9'b00_00_000_0_0, 0, 0);
        nop ("rs_release",1, 0, 9'b00_00_000_1_0, 0, 0);
        step("rs_discard",1, 1, 5'd16, 5'd0, 1, 0, 5'd1, 1, 0, 0, 0, 9'b00_00_000_1_0, 0, 0);
        @(posedge clk);
        done = 1'b1;
    end

    // scoreboard monitor + final report
    initial begin
        logic [W-1:0] act;
        logic [W-1:0] expv;
        string        nm;
        int           guard;
        guard = 0;
        while (!(done && exp_q.size() == 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                nm   = name_q.pop_front();
                act  = {bus.wb2d_a, bus.wb2d_b, bus.x_fwd_a, bus.x_fwd_b, bus.stall_f,
                        bus.stall_d, bus.kill_d, bus.pipe_adv, (state == LUSTALL),
                        bus.stall_cnt, bus.flush_cnt};
                checks++;
                if (act !== expv) begin
                    errors++;
                    $display("FAIL %s: got flags=%b stall=%0d flush=%0d, expected flags=%b stall=%0d flush=%0d",
                             nm, act[W-1:2*CW], act[2*CW-1:CW], act[CW-1:0],
                             expv[W-1:2*CW], expv[2*CW-1:CW], expv[CW-1:0]);
                end
            end
        end
        if (guard >= 2000) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
